// File: rtl/bnn_pkg.sv
// Shared constants, opcodes, FSM states and decoded-command bundle
// for the BNN command sequencer.
package bnn_pkg;

    localparam int NUM_NEURONS = 4;
    localparam int NUM_INPUTS  = 6;
    localparam int THR_W       = 3;
    localparam int IDX_W       = $clog2(NUM_NEURONS);

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_LOAD_W = 2'b01,
        OP_LOAD_T = 2'b10,
        OP_INFER  = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        PAY_W,
        PAY_T,
        EVAL,
        HOLD
    } state_t;

    typedef struct packed {
        opcode_t               op;
        logic [IDX_W-1:0]      idx;
        logic                  nop_clr;
        logic                  w_legal;
        logic                  t_legal;
        logic [NUM_INPUTS-1:0] vec;
        logic [NUM_INPUTS-1:0] w_data;
        logic [NUM_INPUTS-1:0] t_data;
    } cmd_t;

endpackage

// File: rtl/bnn_seq_ctrl_if.sv
// Byte command stream in, inference result stream out.
// Both directions use valid/ready handshakes.
interface bnn_seq_ctrl_if;
    import bnn_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [7:0]             in_byte;
    logic                   out_valid;
    logic                   out_ready;
    logic [NUM_NEURONS-1:0] out_result;

    modport master (
        output in_valid, in_byte, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_byte, out_ready,
        output in_ready, out_valid, out_result
    );

endinterface

// File: rtl/bnn_cmd_decode.sv
// Combinational decode of one command byte, read either as a header
// or as a payload. The burst output exists only with BNN_BURST_EN.
module bnn_cmd_decode
    import bnn_pkg::*;
(
    input  logic [7:0] in_byte,
`ifdef BNN_BURST_EN
    output logic       burst,
`endif
    output cmd_t       cmd
);

    always_comb begin
        cmd         = '0;
        cmd.op      = opcode_t'(in_byte[7:6]);
        cmd.idx     = in_byte[IDX_W-1:0];
        cmd.nop_clr = (in_byte[7:6] == OP_NOP) && in_byte[0];
        cmd.w_legal = (in_byte[7:6] == 2'b00);
        cmd.t_legal = (in_byte[7:THR_W] == '0);
        cmd.vec     = in_byte[NUM_INPUTS-1:0];
        cmd.w_data  = in_byte[NUM_INPUTS-1:0];
        cmd.t_data  = {{(NUM_INPUTS-THR_W){1'b0}}, in_byte[THR_W-1:0]};
    end

`ifdef BNN_BURST_EN
    assign burst = in_byte[5];
`endif

endmodule

// File: rtl/bnn_seq_ctrl.sv
// Byte-serial command sequencer for the 4x6 binary neural network core.
// Optional feature macro: BNN_BURST_EN (multi-payload LOAD bursts).
module bnn_seq_ctrl
    import bnn_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    bnn_seq_ctrl_if.slave          bus,
    output logic                   cfg_we,
    output logic                   cfg_sel,
    output logic [IDX_W-1:0]       cfg_idx,
    output logic [NUM_INPUTS-1:0]  cfg_data,
    output logic [NUM_INPUTS-1:0]  core_data,
    input  logic [NUM_NEURONS-1:0] core_result,
    output logic                   err
);

    state_t                 state;
    cmd_t                   cmd;
    logic [IDX_W-1:0]       idx_q;
    logic                   out_valid_q;
    logic [NUM_NEURONS-1:0] out_result_q;
    logic                   accept;
    logic                   pay_legal;
    logic                   pay_last;

`ifdef BNN_BURST_EN
    logic                   burst_hdr;
    logic                   burst_q;
    logic [IDX_W-1:0]       bcnt;

    assign pay_last = !burst_q || (bcnt == IDX_W'(NUM_NEURONS - 1));
`else
    assign pay_last = 1'b1;
`endif

    bnn_cmd_decode u_dec (
        .in_byte (bus.in_byte),
`ifdef BNN_BURST_EN
        .burst   (burst_hdr),
`endif
        .cmd     (cmd)
    );

    assign bus.in_ready   = (state == IDLE) || (state == PAY_W) ||
                            (state == PAY_T);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign accept         = bus.in_valid && bus.in_ready;
    assign pay_legal      = (state == PAY_T) ? cmd.t_legal : cmd.w_legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            idx_q        <= '0;
            cfg_we       <= 1'b0;
            cfg_sel      <= 1'b0;
            cfg_idx      <= '0;
            cfg_data     <= '0;
            core_data    <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            err          <= 1'b0;
`ifdef BNN_BURST_EN
            burst_q      <= 1'b0;
            bcnt         <= '0;
`endif
        end else begin
            cfg_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        unique case (cmd.op)
                            OP_NOP: begin
                                if (cmd.nop_clr) err <= 1'b0;
                            end
                            OP_LOAD_W, OP_LOAD_T: begin
                                idx_q <= cmd.idx;
                                state <= (cmd.op == OP_LOAD_W) ? PAY_W : PAY_T;
`ifdef BNN_BURST_EN
                                burst_q <= burst_hdr;
                                bcnt    <= '0;
`endif
                            end
                            OP_INFER: begin
                                core_data <= cmd.vec;
                                state     <= EVAL;
                            end
                        endcase
                    end
                end
                PAY_W, PAY_T: begin
                    if (accept) begin
                        // illegal payloads still consume a burst slot
                        if (pay_legal) begin
                            cfg_we   <= 1'b1;
                            cfg_sel  <= (state == PAY_T);
                            cfg_idx  <= idx_q;
                            cfg_data <= (state == PAY_T) ? cmd.t_data
                                                         : cmd.w_data;
                        end else begin
                            err <= 1'b1;
                        end
`ifdef BNN_BURST_EN
                        idx_q <= idx_q + 1'b1;
                        bcnt  <= bcnt + 1'b1;
`endif
                        if (pay_last) state <= IDLE;
                    end
                end
                EVAL: begin
                    out_result_q <= core_result;
                    out_valid_q  <= 1'b1;
                    state        <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Bench for bnn_seq_ctrl: behavioural core model plus a command-level
// reference model of expected writes, error flag and inference results.
module tb_bnn_seq_ctrl;
    import bnn_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_we, cfg_sel, err;
    logic [1:0] cfg_idx;
    logic [5:0] cfg_data, core_data;
    logic [3:0] core_result;

    always #5 clk = ~clk;

    bnn_seq_ctrl_if bus ();

    bnn_seq_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_idx     (cfg_idx),
        .cfg_data    (cfg_data),
        .core_data   (core_data),
        .core_result (core_result),
        .err         (err)
    );

    // Core stand-in: neuron fires when XNOR matches exceed its threshold
    logic [5:0] core_w [4] = '{default: '0};
    logic [2:0] core_t [4] = '{default: '0};

    always_comb begin
        core_result = '0;
        for (int n = 0; n < 4; n++)
            core_result[n] = ($countones(~(core_w[n] ^ core_data)) > int'(core_t[n]));
    end

    logic [8:0] wr_q [$];
    logic [8:0] exp_wr_q [$];
    logic [3:0] res_q [$];
    logic [3:0] exp_res_q [$];
    int         res_cyc [$];
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cfg_we) begin
            wr_q.push_back({cfg_sel, cfg_idx, cfg_data});
            if (cfg_sel) core_t[cfg_idx] <= cfg_data[2:0];
            else         core_w[cfg_idx] <= cfg_data;
        end
        if (bus.out_valid && bus.out_ready) begin
            res_q.push_back(bus.out_result);
            res_cyc.push_back(cyc);
        end
    end

    // Reference state
    logic [5:0] exp_w [4] = '{default: '0};
    logic [2:0] exp_t [4] = '{default: '0};
    logic       exp_err = 1'b0;
    int         n_assert = 0;
    int         n_fail = 0;
    bit         rr_on = 1'b0;

    function automatic logic [3:0] ref_infer(input logic [5:0] v);
        logic [3:0] r;
        int         m;
        r = '0;
        for (int n = 0; n < 4; n++) begin
            m = 0;
            for (int b = 0; b < 6; b++)
                if (exp_w[n][b] == v[b]) m++;
            r[n] = (m > int'(exp_t[n]));
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", {31'b0, bus.in_ready}, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic load(input logic t, input logic [1:0] i,
                        input logic [7:0] p);
        send_byte(t ? (8'h80 | {6'b0, i}) : (8'h40 | {6'b0, i}));
        send_byte(p);
        if (!t) begin
            if (p[7:6] == 2'b00) begin
                exp_w[i] = p[5:0];
                exp_wr_q.push_back({1'b0, i, p[5:0]});
            end else exp_err = 1'b1;
        end else begin
            if (p <= 8'd7) begin
                exp_t[i] = p[2:0];
                exp_wr_q.push_back({1'b1, i, 3'b000, p[2:0]});
            end else exp_err = 1'b1;
        end
    endtask

    task automatic infer(input logic [5:0] v);
        exp_res_q.push_back(ref_infer(v));
        send_byte({2'b11, v});
    endtask

    task automatic check_writes(input string tag);
        tick(2);
        check({tag, "_count"}, wr_q.size(), exp_wr_q.size());
        for (int i = 0; i < wr_q.size() && i < exp_wr_q.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), {23'b0, wr_q[i]},
                  {23'b0, exp_wr_q[i]});
        wr_q.delete();
        exp_wr_q.delete();
    endtask

    task automatic check_results(input string tag);
        check({tag, "_count"}, res_q.size(), exp_res_q.size());
        for (int i = 0; i < res_q.size() && i < exp_res_q.size(); i++)
            check($sformatf("%s_res%0d", tag, i), {28'b0, res_q[i]},
                  {28'b0, exp_res_q[i]});
    endtask

    initial begin
        int w;
        int r;
        logic [7:0] p;
        bus.in_valid  = 1'b0;
        bus.in_byte   = 8'h00;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick(1);
        check("rst_in_ready", {31'b0, bus.in_ready}, 1);
        check("rst_out_valid", {31'b0, bus.out_valid}, 0);
        check("rst_err", {31'b0, err}, 0);
        check("rst_cfg_we", {31'b0, cfg_we}, 0);
        check("rst_core_data", {26'b0, core_data}, 0);
        check("rst_out_result", {28'b0, bus.out_result}, 0);

        // Reset in the middle of a weight load drops the command
        send_byte(8'h41);
        check("payw_in_ready", {31'b0, bus.in_ready}, 1);
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick(2);
        check("midrst_in_ready", {31'b0, bus.in_ready}, 1);
        check("midrst_out_valid", {31'b0, bus.out_valid}, 0);
        check("midrst_err", {31'b0, err}, 0);
        send_byte(8'h2B);
        tick(1);
        check("midrst_no_write", wr_q.size(), 0);

        // Directed config writes
        load(1'b0, 2'd2, 8'h2A);
        check("w_we", {31'b0, cfg_we}, 1);
        check("w_sel", {31'b0, cfg_sel}, 0);
        check("w_idx", {30'b0, cfg_idx}, 2);
        check("w_data", {26'b0, cfg_data}, 32'h2A);
        tick(1);
        check("w_we_one_cycle", {31'b0, cfg_we}, 0);
        load(1'b1, 2'd3, 8'h02);
        check("t_we", {31'b0, cfg_we}, 1);
        check("t_sel", {31'b0, cfg_sel}, 1);
        check("t_idx", {30'b0, cfg_idx}, 3);
        check("t_data", {26'b0, cfg_data}, 2);
        load(1'b1, 2'd1, 8'h08);
        check("t_bad_no_we", {31'b0, cfg_we}, 0);
        check("t_bad_err", {31'b0, err}, 1);
        send_byte(8'h01);
        exp_err = 1'b0;
        check("nop_clr_err", {31'b0, err}, 0);
        load(1'b1, 2'd0, 8'h07);
        check("t7_data", {26'b0, cfg_data}, 7);
        check_writes("dir");

        // Inference with a stalled consumer
        load(1'b0, 2'd0, 8'h38);
        load(1'b0, 2'd1, 8'h07);
        load(1'b0, 2'd2, 8'h0C);
        load(1'b0, 2'd3, 8'h33);
        for (int i = 0; i < 4; i++) load(1'b1, i[1:0], 8'h03);
        check_writes("net");
        send_byte(8'hF8);
        check("eval_in_ready", {31'b0, bus.in_ready}, 0);
        check("eval_out_valid", {31'b0, bus.out_valid}, 0);
        check("eval_core_data", {26'b0, core_data}, 32'h38);
        tick(1);
        check("hold_out_valid", {31'b0, bus.out_valid}, 1);
        check("hold_result", {28'b0, bus.out_result}, 4'b0001);
        check("hold_ref", {28'b0, bus.out_result}, {28'b0, ref_infer(6'h38)});
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("hold_stable", {28'b0, bus.out_result}, 4'b0001);
            check("hold_valid", {31'b0, bus.out_valid}, 1);
            check("hold_in_ready", {31'b0, bus.in_ready}, 0);
        end
        bus.out_ready = 1'b1;
        tick(1);
        check("hs_out_valid", {31'b0, bus.out_valid}, 0);
        check("hs_in_ready", {31'b0, bus.in_ready}, 1);
        check("hs_core_hold", {26'b0, core_data}, 32'h38);
        check("hs_count", res_q.size(), 1);
        res_q.delete();
        res_cyc.delete();

        // Randomised config stream against the command model
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                p = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom & 8'h3F);
                load(1'b0, 2'($urandom), p);
            end else if (r < 8) begin
                p = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
                load(1'b1, 2'($urandom), p);
            end else begin
                p = {2'b00, 6'($urandom)};
                send_byte(p);
                if (p[0]) exp_err = 1'b0;
            end
        end
        check_writes("rnd");
        check("rnd_err", {31'b0, err}, {31'b0, exp_err});

        // Back-to-back inferences, consumer always ready
        for (int i = 0; i < 4; i++) infer(6'($urandom));
        w = 0;
        while (res_q.size() < 4 && w < 40) begin
            @(posedge clk);
            w++;
        end
        #1;
        check_results("b2b");
        for (int i = 1; i < res_cyc.size(); i++)
            check($sformatf("b2b_gap%0d", i), res_cyc[i] - res_cyc[i-1], 3);
        res_q.delete();
        res_cyc.delete();
        exp_res_q.delete();

        // Stalling producer and consumer
        rr_on = 1'b1;
        fork
            while (rr_on) begin
                @(posedge clk);
                #2 bus.out_ready = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            infer(6'($urandom));
        end
        rr_on = 1'b0;
        repeat (2) @(posedge clk);
        #3 bus.out_ready = 1'b1;
        w = 0;
        while (res_q.size() < 16 && w < 200) begin
            @(posedge clk);
            w++;
        end
        #1;
        check_results("stall");
        tick(1);

        // LOAD_W header with bit 5 set
        send_byte(8'h63);
        send_byte(8'h15);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
`ifdef BNN_BURST_EN
        exp_wr_q.push_back({1'b0, 2'd3, 6'h15});
        exp_wr_q.push_back({1'b0, 2'd0, 6'h01});
        exp_wr_q.push_back({1'b0, 2'd1, 6'h02});
        exp_wr_q.push_back({1'b0, 2'd2, 6'h03});
`else
        exp_wr_q.push_back({1'b0, 2'd3, 6'h15});
        exp_err = 1'b0;
`endif
        check_writes("burst");
        check("burst_err", {31'b0, err}, {31'b0, exp_err});
        check("burst_in_ready", {31'b0, bus.in_ready}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bnn_seq_ctrl.md
# bnn_seq_ctrl

Byte-serial command controller that configures and sequences the 4-neuron, 6-input binary neural network core. It accepts a valid/ready byte stream and decodes weight-load, threshold-load and inference commands. It drives the core's configuration write port and data input, then returns each inference result on a valid/ready output. It sits between the pin-level interface and the XNOR-popcount/threshold datapath, replacing free-running `load_en` sequencing with explicit addressed writes.

## Interface
- `NUM_NEURONS`, default 4: neurons in the core; sets index width to 2.
- `NUM_INPUTS`, default 6: input and weight bits per neuron.
- `THR_W`, default 3: threshold width, covering popcount range 0..6.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: command byte valid.
- `in_ready`  out  1: controller accepts a byte. Combinational from state.
- `in_byte`  in  8: command or payload byte.
- `cfg_we`  out  1: one-cycle write strobe to the core.
- `cfg_sel`  out  1: 0 selects the weight register, 1 selects the threshold register.
- `cfg_idx`  out  2: target neuron.
- `cfg_data`  out  6: weight bits. For thresholds, only `[THR_W-1:0]` is used; upper bits are 0.
- `core_data`  out  6: registered input vector to the core.
- `core_result`  in  4: combinational neuron outputs from the core.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: result consumer ready.
- `out_result`  out  4: captured neuron outputs.
- `err`  out  1: sticky protocol error.

## Operation
- Header byte opcode is `in_byte[7:6]`:
  - `00` NOP. If bit0 is 1, clears `err`.
  - `01` LOAD_W. Neuron index in `[1:0]`; one payload byte follows.
  - `10` LOAD_T. Neuron index in `[1:0]`; one payload byte follows.
  - `11` INFER. Input vector in `[5:0]`; no payload.
- FSM states: IDLE, PAY_W, PAY_T, EVAL, HOLD. Reset state is IDLE.
- IDLE:
  - Accepted LOAD_W goes to PAY_W and latches the index.
  - Accepted LOAD_T goes to PAY_T and latches the index.
  - Accepted INFER loads `core_data` and goes to EVAL.
  - NOP stays in IDLE.
- PAY_W:
  - On an accepted payload with `[7:6]==0`: `cfg_we`=1 and `cfg_sel`=0 for one cycle, `cfg_data`=payload`[5:0]`, then return to IDLE.
  - If `[7:6]!=0`: no write, `err`<=1, return to IDLE.
- PAY_T:
  - Same as PAY_W, but the legal payload has `[7:3]==0`, and `cfg_sel`=1.
  - A threshold greater than 6 but within 3 bits (value 7) is legal and is written.
- EVAL: lasts exactly one cycle. At its end, `out_result`<=`core_result`, `out_valid`<=1, go to HOLD.
- HOLD: wait for `out_valid`&`out_ready`. On that handshake, `out_valid`<=0 and go to IDLE.
- `in_ready`=1 only in IDLE, PAY_W and PAY_T.
- Reset values:
  - All outputs 0, except `in_ready`=1.
  - `core_data`=0, `err`=0.
  - The latched index is cleared.
  - Core weight/threshold storage is not touched by this block.
- Reset mid-payload or mid-inference: the partial command is dropped with no `cfg_we`, and a pending `out_valid` is lost.
- `core_data` holds its last INFER value between inferences.

## Timing
- Byte accepted at the rising edge where `in_valid`&`in_ready`. Upstream may hold `in_valid` across stalls with the byte stable.
- Config write: `cfg_we` is high during the cycle after payload acceptance, and `cfg_idx`, `cfg_sel` and `cfg_data` are stable in that cycle. The header plus payload take 2 accepted bytes; the write follows at edge +1.
- Inference:
  - INFER accepted at edge T.
  - EVAL during cycle T..T+1.
  - `out_valid`=1 from edge T+1 onward.
  - Minimum 3-cycle turnaround back to IDLE when `out_ready` is tied high.
- `out_result` and `out_valid` are registered, with no combinational path from `in_*`.
- A NOP or LOAD may not overlap HOLD; `in_ready` stays 0 until the cycle after the output handshake.

## Configuration
- `BNN_BURST_EN`: when defined, header bit 5 set on LOAD_W or LOAD_T starts a burst.
  - The burst accepts `NUM_NEURONS` consecutive payloads written to idx, idx+1, …, wrapping modulo 4.
  - A 2-bit burst counter stays in PAY_W/PAY_T until 4 payloads are consumed.
  - An illegal payload sets `err`, skips that write, and still advances the index.
- Without the macro: bit 5 is ignored, and every LOAD takes exactly one payload.

## Structure
- Package `bnn_pkg`: `NUM_NEURONS`, `NUM_INPUTS`, `THR_W`, opcode constants (OP_NOP/OP_LOAD_W/OP_LOAD_T/OP_INFER), FSM state enum.
- One sub-module: `bnn_cmd_decode`, combinational. It decodes opcode, index, burst bit and payload legality.
- FSM, counters and output registers live in the top.

## Test plan
- Reset asserted mid-PAY_W -> no `cfg_we`; after release `in_ready`=1, `out_valid`=0, `err`=0, state IDLE.
- Send 0x42 then 0x2A -> one `cfg_we` cycle with `cfg_sel`=0, `cfg_idx`=2, `cfg_data`=0x2A.
- Send 0x83 then 0x02 -> `cfg_sel`=1, `cfg_idx`=3, `cfg_data`=0x02. Then send 0x81 then 0x08 -> no write, `err`=1. Then send 0x01 -> `err`=0.
- Core model loaded with weights 111000/000111/001100/110011 and thresholds 3. Send INFER 0xF8 with `out_ready` low for 4 cycles -> `out_valid` rises at T+1, `out_result`=4'b0001 held stable, `in_ready`=0 until the cycle after the handshake.
- Back-to-back INFERs with `out_ready`=1 -> one result every 3 cycles, with no byte dropped across upstream `in_valid` stalls.
- With `BNN_BURST_EN`, send 0x63 then 4 payloads -> writes to idx 3,0,1,2 in order. Without the macro, the same stream writes idx 3 once, and the next payload bytes are decoded as headers.
